// File: rtl/iir_coef_calc_if.sv
// Coefficient bus of iir_coef_calc: packed per-channel bandwidths in, packed coefficients out.
// Handshake: no backpressure. a/a_valid are level-held, upd is a one-cycle strobe naming upd_ch.
interface iir_coef_calc_if #(
  parameter int CHANNELS = 4,
  parameter int BW_W     = 16,
  parameter int A_W      = 18
) ();
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*BW_W-1:0] Bandwidth;
  logic [CHANNELS*A_W-1:0]  a;
  logic [CHANNELS-1:0]      a_valid;
  logic                     upd;
  logic [CH_W-1:0]          upd_ch;
  logic                     busy;

  modport master (output Bandwidth, input a, a_valid, upd, upd_ch, busy);
  modport slave  (input Bandwidth, output a, a_valid, upd, upd_ch, busy);
endinterface

// File: rtl/iir_coef_calc.sv
// Multi-channel smoothing coefficient a = FS/(FS + pi*bw), Q1.(A_W-1), one shared multiplier.
// Define IIR_COEF_ROUND_EN for a guard bit with round-half-up and saturation.
module iir_coef_calc #(
  parameter int CHANNELS = 4,
  parameter int BW_W     = 16,
  parameter int A_W      = 18,
  parameter int FS       = 50_000
) (
  input  logic           Clk,
  input  logic           nReset,
  iir_coef_calc_if.slave bus,
  output logic [2:0]     fsm_state
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
`ifdef IIR_COEF_ROUND_EN
  localparam int X_W = A_W + 1;
`else
  localparam int X_W = A_W;
`endif
  localparam int Y_W  = A_W + 2;
  localparam int MA_W = (X_W > BW_W) ? X_W : BW_W;
  localparam int MB_W = (Y_W > 18) ? Y_W : 18;
  localparam int P_W  = MA_W + MB_W;
  localparam logic [17:0]     PI_Q    = 18'h3243F;
  localparam logic [P_W-1:0]  NUM     = P_W'(FS) << (X_W - 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  typedef enum logic [2:0] {SCAN = 3'd0, LOAD = 3'd1, MUL = 3'd2, BIT = 3'd3, WRITE = 3'd4} state_t;
  state_t state, state_nx;

  logic [BW_W-1:0]     bw_q    [CHANNELS];
  logic [BW_W-1:0]     last_bw [CHANNELS];
  logic [CHANNELS-1:0] stale;
  logic [CH_W-1:0]     scan_ch, ch;
  logic [BW_W-1:0]     bw_lat;
  logic [Y_W-1:0]      prod_q, y;
  logic [X_W-1:0]      x, mask;
  logic [MA_W-1:0]     mul_a;
  logic [MB_W-1:0]     mul_b;
  logic [P_W-1:0]      mul_p;
  logic [A_W-1:0]      result;
  logic                cand_stale, clip;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (c == LAST_CH) ? '0 : c + CH_W'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < CHANNELS; k++)
      stale[k] = !bus.a_valid[k] || (bw_q[k] != last_bw[k]);
  end

  // While writing, the channel being written is judged against the value it is about to record.
  assign cand_stale = (scan_ch == ch) ? (bw_q[scan_ch] != bw_lat) : stale[scan_ch];
  assign clip       = (32'(bw_lat) >= 32'(FS / 2));

  // One multiplier: pi*bw during LOAD, trial*y during the divide.
  always_comb begin
    mul_a = MA_W'(x | mask);
    mul_b = MB_W'(y);
    if (state == LOAD) begin
      mul_a = MA_W'(bw_lat);
      mul_b = MB_W'(PI_Q);
    end
  end
  assign mul_p = P_W'(mul_a) * P_W'(mul_b);

`ifdef IIR_COEF_ROUND_EN
  logic [A_W:0] half;
  assign half   = {1'b0, x[A_W:1]} + (A_W+1)'(x[0]);
  assign result = half[A_W] ? {A_W{1'b1}} : half[A_W-1:0];
`else
  assign result = x;
`endif

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= SCAN;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SCAN:    if (stale[scan_ch]) state_nx = LOAD;
      LOAD:    state_nx = clip ? WRITE : MUL;
      MUL:     state_nx = BIT;
      BIT:     if (mask == X_W'(1)) state_nx = WRITE;
      WRITE:   state_nx = cand_stale ? LOAD : SCAN;
      default: state_nx = SCAN;
    endcase
  end

  assign bus.busy  = (state != SCAN);
  assign fsm_state = state;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      scan_ch     <= '0;
      ch          <= '0;
      bw_lat      <= '0;
      prod_q      <= '0;
      y           <= '0;
      x           <= '0;
      mask        <= '0;
      bus.a       <= '0;
      bus.a_valid <= '0;
      bus.upd     <= 1'b0;
      bus.upd_ch  <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        bw_q[k]    <= '0;
        last_bw[k] <= '0;
      end
    end else begin
      bus.upd <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        bw_q[k] <= bus.Bandwidth[k*BW_W +: BW_W];
        if (bw_q[k] != last_bw[k]) bus.a_valid[k] <= 1'b0;
      end
      case (state)
        SCAN: begin
          // With nothing stale the pointer parks on the channel after the last one serviced.
          if (stale[scan_ch]) begin
            ch      <= scan_ch;
            bw_lat  <= bw_q[scan_ch];
            scan_ch <= next_ch(scan_ch);
          end else if (|stale) begin
            scan_ch <= next_ch(scan_ch);
          end
        end
        LOAD: begin
          prod_q <= Y_W'(mul_p >> 16);
          x      <= '0;
        end
        MUL: begin
          y    <= Y_W'(FS) + prod_q;
          x    <= '0;
          mask <= {1'b1, {(X_W-1){1'b0}}};
        end
        BIT: begin
          if (mul_p <= NUM) x <= x | mask;
          mask <= mask >> 1;
        end
        WRITE: begin
          bus.a[ch*A_W +: A_W] <= result;
          last_bw[ch]          <= bw_lat;
          bus.a_valid[ch]      <= (bw_q[ch] == bw_lat);
          bus.upd              <= 1'b1;
          bus.upd_ch           <= ch;
          if (cand_stale) begin
            ch      <= scan_ch;
            bw_lat  <= bw_q[scan_ch];
            scan_ch <= next_ch(scan_ch);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iir_coef_calc.sv
// Directed bench for iir_coef_calc (FS=50000, A_W=18, CHANNELS=4) with hand-computed coefficients.
module tb_iir_coef_calc;
  localparam int A_W = 18;
  localparam int BW_W = 16;
  localparam int E0 = 131072;
  localparam int E24999 = 50986;
`ifdef IIR_COEF_ROUND_EN
  localparam int LAT = 22;
  localparam int E1000 = 123325;
  localparam int E5000 = 99740;
`else
  localparam int LAT = 21;
  localparam int E1000 = 123324;
  localparam int E5000 = 99739;
`endif

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic [2:0] fsm_state;
  int         checks = 0;
  int         errors = 0;

  iir_coef_calc_if bus ();
  iir_coef_calc dut (.Clk(Clk), .nReset(nReset), .bus(bus), .fsm_state(fsm_state));

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [A_W-1:0] a_of(input int k);
    return bus.a[k*A_W +: A_W];
  endfunction

  task automatic set_bw(input int k, input int v);
    bus.Bandwidth[k*BW_W +: BW_W] = BW_W'(v);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wait_upd(input int limit, output bit got, output int cyc, output int busy_cyc);
    got = 0;
    cyc = 0;
    busy_cyc = 0;
    while (!got && cyc < limit) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (bus.busy) busy_cyc++;
      if (bus.upd) got = 1;
    end
  endtask

  task automatic wait_bit(output bit seen);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge Clk);
      #1;
      if (fsm_state == 3'd3) seen = 1;
    end
  endtask

  initial begin
    bit got, seen;
    int cyc, bc, n_upd, busy_cnt, rises;
    bit prev_busy;
    int exp_v[4];
    int upd_chs[4];
    int upd_val[4];

    bus.Bandwidth = '0;
    tick(3);
    chk("rst_a", bus.a, 0);
    chk("rst_a_valid", bus.a_valid, 0);
    chk("rst_upd", bus.upd, 0);
    chk("rst_upd_ch", bus.upd_ch, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_state", fsm_state, 0);

    // Power-up: every channel computed once, in order, back to back.
    nReset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_upd(100, got, cyc, bc);
      chk("init_upd_seen", got, 1);
      chk("init_upd_ch", bus.upd_ch, k);
      chk("init_a", a_of(k), E0);
      if (k > 0) chk("init_interval", cyc, LAT);
    end
    tick(1);
    chk("init_a_valid", bus.a_valid, 4'hF);
    chk("init_idle", bus.busy, 0);

    // Single channel change.
    set_bw(1, 1000);
    tick(2);
    chk("ch1_invalidated", bus.a_valid, 4'hD);
    wait_upd(200, got, cyc, bc);
    chk("ch1_upd_seen", got, 1);
    chk("ch1_upd_ch", bus.upd_ch, 1);
    chk("ch1_a", a_of(1), E1000);
    chk("ch1_a_valid", bus.a_valid, 4'hF);
    n_upd = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (bus.upd) n_upd++;
    end
    chk("ch1_no_extra_upd", n_upd, 0);
    chk("ch1_ch0_kept", a_of(0), E0);

    // Clip boundary on ch2, then just below it.
    set_bw(2, 25000);
    wait_upd(100, got, cyc, bc);
    chk("clip25k_seen", got, 1);
    chk("clip25k_latency", bc, 2);
    chk("clip25k_a", a_of(2), 0);
    chk("clip25k_valid", bus.a_valid[2], 1);
    set_bw(2, 40000);
    wait_upd(100, got, cyc, bc);
    chk("clip40k_seen", got, 1);
    chk("clip40k_latency", bc, 2);
    chk("clip40k_a", a_of(2), 0);
    chk("clip40k_valid", bus.a_valid[2], 1);
    set_bw(2, 24999);
    wait_upd(100, got, cyc, bc);
    chk("bw24999_seen", got, 1);
    chk("bw24999_latency", bc, LAT);
    chk("bw24999_a", a_of(2), E24999);

    // ch0 changes, then reverts during its own divide.
    set_bw(0, 1000);
    wait_bit(seen);
    chk("toggle_bit_seen", seen, 1);
    tick(4);
    set_bw(0, 0);
    wait_upd(100, got, cyc, bc);
    chk("toggle_upd_seen", got, 1);
    chk("toggle_upd_ch", bus.upd_ch, 0);
    chk("toggle_a", a_of(0), E1000);
    chk("toggle_not_valid", bus.a_valid[0], 0);
    wait_upd(100, got, cyc, bc);
    chk("rerun_upd_seen", got, 1);
    chk("rerun_upd_ch", bus.upd_ch, 0);
    chk("rerun_a", a_of(0), E0);
    chk("rerun_valid", bus.a_valid[0], 1);

    // Reset in the middle of ch3's divide.
    set_bw(3, 1000);
    wait_bit(seen);
    chk("abort_bit_seen", seen, 1);
    tick(3);
    nReset = 1'b0;
    #1;
    chk("abort_a", bus.a, 0);
    chk("abort_a_valid", bus.a_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_upd", bus.upd, 0);
    chk("abort_state", fsm_state, 0);
    tick(3);
    nReset = 1'b1;
    exp_v = '{E0, E1000, E24999, E1000};
    for (int k = 0; k < 4; k++) begin
      wait_upd(100, got, cyc, bc);
      chk("restart_upd_seen", got, 1);
      chk("restart_upd_ch", bus.upd_ch, k);
      chk("restart_a", a_of(k), exp_v[k]);
      if (k > 0) chk("restart_interval", cyc, LAT);
    end
    tick(1);
    chk("restart_a_valid", bus.a_valid, 4'hF);

    // All channels change in the same cycle.
    set_bw(0, 5000);
    set_bw(1, 0);
    set_bw(2, 1000);
    set_bw(3, 24999);
    exp_v = '{E5000, E0, E1000, E24999};
    n_upd = 0;
    busy_cnt = 0;
    rises = 0;
    prev_busy = 0;
    for (int i = 0; i < 400 && n_upd < 4; i++) begin
      tick(1);
      if (bus.busy) busy_cnt++;
      if (bus.busy && !prev_busy) rises++;
      prev_busy = bus.busy;
      if (bus.upd) begin
        upd_chs[n_upd] = int'(bus.upd_ch);
        upd_val[n_upd] = int'(a_of(int'(bus.upd_ch)));
        n_upd++;
      end
    end
    chk("all4_upd_count", n_upd, 4);
    chk("all4_busy_cycles", busy_cnt, 4 * LAT);
    chk("all4_busy_continuous", rises, 1);
    for (int k = 0; k < n_upd; k++) begin
      chk("all4_order", upd_chs[k], k);
      chk("all4_a", upd_val[k], exp_v[k]);
    end
    tick(1);
    chk("all4_a_valid", bus.a_valid, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
